// File: rtl/route_unscramble_rx.sv
// route_unscramble_rx
//
// Receive side of the 4-bit select router. Routed words (v, y, t, w) arrive
// under a valid/ready handshake; the tag w selects how the operands were
// permuted, and this block undoes that permutation to recover a, b, c and
// the select code s. Recovered words are buffered in a 2-entry FIFO whose
// head drives the outputs. Words with an undecodable tag are dropped,
// flagged with a one-cycle err pulse and counted in a saturating counter.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready  input handshake for v/y/t/w
//   v, y, t             routed data buses (WIDTH bits each)
//   w                   routed tag, equal to the original select code
//   out_valid, out_ready output handshake for a/b/c/s
//   a, b, c, s          recovered operands and select code (FIFO head)
//   err                 one-cycle pulse after an undecodable word is dropped
//   err_count           saturating 8-bit count of dropped words
//   err_clr             synchronous clear of err_count (wins over a drop)

module route_unscramble_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s,
  output logic             err,
  output logic [7:0]       err_count,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  occ_state_t state, state_next;

  logic             wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem_a [2];
  logic [WIDTH-1:0] mem_b [2];
  logic [WIDTH-1:0] mem_c [2];
  logic [WIDTH-1:0] mem_s [2];

  logic             accept, bad_tag, push, pop, drop;
  logic [WIDTH-1:0] dec_a, dec_b, dec_c, dec_s;

  // Both flow-control outputs come straight from the state register, so
  // in_ready never depends combinationally on out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);

  assign accept = in_valid && in_ready;
  assign bad_tag = (w > WIDTH'(5));
  assign push   = accept && !bad_tag;
  assign drop   = accept && bad_tag;
  assign pop    = out_valid && out_ready;

  // Undo the routing permutation. Tag 0 was a straight pass; tags 1..5
  // swapped the first and third operands. The decode for bad tags is
  // irrelevant because those words are never written.
  always_comb begin
    dec_a = v;
    dec_b = y;
    dec_c = t;
    dec_s = '0;
    if (w != '0) begin
      dec_a = t;
      dec_b = y;
      dec_c = v;
      dec_s = w;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Occupancy next-state. A push in TWO or a pop in EMPTY cannot happen
  // because in_ready and out_valid are derived from the state.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = TWO;
        else if (pop && !push) state_next = EMPTY;
      end
      TWO:   if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // FIFO storage and 1-bit wrapping pointers. Contents are cleared on reset
  // so the outputs read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      mem_a[0] <= '0;
      mem_a[1] <= '0;
      mem_b[0] <= '0;
      mem_b[1] <= '0;
      mem_c[0] <= '0;
      mem_c[1] <= '0;
      mem_s[0] <= '0;
      mem_s[1] <= '0;
    end else begin
      if (push) begin
        mem_a[wr_ptr] <= dec_a;
        mem_b[wr_ptr] <= dec_b;
        mem_c[wr_ptr] <= dec_c;
        mem_s[wr_ptr] <= dec_s;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // The head entry is a registered location, so outputs stay stable while
  // the consumer stalls.
  assign a = mem_a[rd_ptr];
  assign b = mem_b[rd_ptr];
  assign c = mem_c[rd_ptr];
  assign s = mem_s[rd_ptr];

  // Drop reporting. The clear has priority over a same-cycle increment,
  // but the err pulse still reports the drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err <= drop;
      if (err_clr) begin
        err_count <= 8'd0;
      end else if (drop && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
